// File: rtl/mesh_packet_buffer.sv
// Elastic FIFO between two mesh nodes: four-phase Req/Ack slave port in,
// four-phase Req/Ack master port out, words delivered in arrival order.
module mesh_packet_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  S_Req,
    output logic                  S_Ack,
    input  logic [DATA_WIDTH-1:0] S_Data,
    output logic                  M_Req,
    input  logic                  M_Ack,
    output logic [DATA_WIDTH-1:0] M_Data
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {SIdle, SAck} s_state_e;
    typedef enum logic [1:0] {MIdle, MReq, MWait} m_state_e;

    s_state_e              s_state_q;
    m_state_e              m_state_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [AW:0]           count_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Both flags come from the registered count, so a same-cycle pop never
    // frees space for that cycle's push.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = (s_state_q == SIdle) && S_Req && !full;
    assign pop   = (m_state_q == MReq) && M_Ack;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wptr_q] <= S_Data;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s_state_q <= SIdle;
            S_Ack     <= 1'b0;
            wptr_q    <= '0;
        end else begin
            case (s_state_q)
                SIdle: begin
                    if (push) begin
                        wptr_q    <= wptr_q + AW'(1);
                        S_Ack     <= 1'b1;
                        s_state_q <= SAck;
                    end
                end
                SAck: begin
                    if (!S_Req) begin
                        S_Ack     <= 1'b0;
                        s_state_q <= SIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            m_state_q <= MIdle;
            M_Req     <= 1'b0;
            M_Data    <= '0;
            rptr_q    <= '0;
        end else begin
            case (m_state_q)
                MIdle: begin
                    if (!empty) begin
                        M_Data    <= mem[rptr_q];
                        M_Req     <= 1'b1;
                        m_state_q <= MReq;
                    end
                end
                MReq: begin
                    if (M_Ack) begin
                        rptr_q    <= rptr_q + AW'(1);
                        M_Req     <= 1'b0;
                        m_state_q <= MWait;
                    end
                end
                MWait: begin
                    if (!M_Ack) begin
                        m_state_q <= MIdle;
                    end
                end
                default: begin
                    M_Req     <= 1'b0;
                    m_state_q <= MIdle;
                end
            endcase
        end
    end

    // The offered word stays counted until the downstream acknowledges it.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_packet_buffer.sv
// Self-checking bench for mesh_packet_buffer: directed handshake cases plus
// randomized traffic checked against an in-order queue model.
module tb_mesh_packet_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int          BOUND = 200;

    logic          Clock;
    logic          nReset;
    logic          S_Req;
    logic          S_Ack;
    logic [DW-1:0] S_Data;
    logic          M_Req;
    logic          M_Ack;
    logic [DW-1:0] M_Data;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];

    mesh_packet_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .Clock (Clock),
        .nReset(nReset),
        .S_Req (S_Req),
        .S_Ack (S_Ack),
        .S_Data(S_Data),
        .M_Req (M_Req),
        .M_Ack (M_Ack),
        .M_Data(M_Data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_s_ack(input logic lvl, input string tag);
        int n = 0;
        while (S_Ack !== lvl && n < BOUND) begin
            tick();
            n++;
        end
        check_val(tag, {31'b0, S_Ack}, {31'b0, lvl});
    endtask

    task automatic wait_m_req(input logic lvl, input string tag);
        int n = 0;
        while (M_Req !== lvl && n < BOUND) begin
            tick();
            n++;
        end
        check_val(tag, {31'b0, M_Req}, {31'b0, lvl});
    endtask

    task automatic send_word(input logic [DW-1:0] data);
        S_Data = data;
        S_Req  = 1'b1;
        wait_s_ack(1'b1, "s_ack_rise");
        S_Req  = 1'b0;
        wait_s_ack(1'b0, "s_ack_fall");
    endtask

    task automatic recv_word(output logic [DW-1:0] data);
        wait_m_req(1'b1, "m_req_rise");
        data  = M_Data;
        M_Ack = 1'b1;
        wait_m_req(1'b0, "m_req_fall");
        M_Ack = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] exp;

        // Reset with both handshake inputs asserted
        nReset = 1'b0;
        S_Req  = 1'b1;
        M_Ack  = 1'b1;
        S_Data = 32'hDEAD_BEEF;
        repeat (3) tick();
        check_val("rst_s_ack", {31'b0, S_Ack}, 32'd0);
        check_val("rst_m_req", {31'b0, M_Req}, 32'd0);
        check_val("rst_m_data", M_Data, 32'd0);
        S_Req = 1'b0;
        M_Ack = 1'b0;
        tick();
        nReset = 1'b1;
        repeat (3) tick();
        check_val("post_rst_m_req", {31'b0, M_Req}, 32'd0);

        // Single word latency
        S_Data = 32'h7;
        S_Req  = 1'b1;
        tick();
        check_val("single_s_ack", {31'b0, S_Ack}, 32'd1);
        check_val("single_m_req_early", {31'b0, M_Req}, 32'd0);
        S_Req = 1'b0;
        tick();
        check_val("single_m_req", {31'b0, M_Req}, 32'd1);
        check_val("single_m_data", M_Data, 32'h7);
        check_val("single_s_ack_fall", {31'b0, S_Ack}, 32'd0);
        M_Ack = 1'b1;
        tick();
        check_val("single_pop", {31'b0, M_Req}, 32'd0);
        M_Ack = 1'b0;
        repeat (3) tick();
        check_val("single_once", {31'b0, M_Req}, 32'd0);

        // Burst against a stalled receiver
        for (int i = 7; i <= 10; i++) send_word(DW'(i));
        check_val("burst_m_req", {31'b0, M_Req}, 32'd1);
        check_val("burst_head", M_Data, 32'd7);
        for (int i = 7; i <= 10; i++) begin
            recv_word(got);
            check_val("burst_order", got, DW'(i));
        end

        // Fill to DEPTH, ninth word must be held off
        for (int i = 1; i <= DEPTH; i++) send_word(DW'(i));
        S_Data = DW'(DEPTH + 1);
        S_Req  = 1'b1;
        repeat (4) tick();
        check_val("full_backpressure", {31'b0, S_Ack}, 32'd0);
        check_val("full_head", M_Data, 32'd1);
        recv_word(got);
        check_val("full_first_pop", got, 32'd1);
        wait_s_ack(1'b1, "full_late_ack");
        S_Req = 1'b0;
        wait_s_ack(1'b0, "full_late_ack_fall");
        for (int i = 2; i <= DEPTH + 1; i++) begin
            recv_word(got);
            check_val("full_drain", got, DW'(i));
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) send_word(32'h100 + DW'(i));
        wait_m_req(1'b1, "midrst_m_req");
        #2;
        nReset = 1'b0;
        #1;
        check_val("midrst_m_req_clr", {31'b0, M_Req}, 32'd0);
        check_val("midrst_m_data_clr", M_Data, 32'd0);
        check_val("midrst_s_ack_clr", {31'b0, S_Ack}, 32'd0);
        tick();
        nReset = 1'b1;
        repeat (3) tick();
        check_val("midrst_discard", {31'b0, M_Req}, 32'd0);
        send_word(32'hABCD);
        recv_word(got);
        check_val("midrst_first_out", got, 32'hABCD);

        // Randomized concurrent traffic against a queue model
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    logic [DW-1:0] w;
                    w = $urandom;
                    repeat ($urandom_range(0, 3)) tick();
                    model_q.push_back(w);
                    send_word(w);
                end
            end
            begin
                for (int i = 0; i < 48; i++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    recv_word(got);
                    if (model_q.size() == 0) begin
                        check_val("rand_unexpected", got, 32'hX);
                    end else begin
                        exp = model_q.pop_front();
                        check_val("rand_order", got, exp);
                    end
                end
            end
        join
        repeat (4) tick();
        check_val("rand_no_extra", {31'b0, M_Req}, 32'd0);
        check_val("rand_model_empty", model_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
